// File: rtl/datapath_sequencer.sv
// Sequencer driving a datapath: loads registers from init beats, then replays a stored program.
// Optional macro SEQ_SINGLE_STEP_EN adds a step input that gates RUN progress.
module datapath_sequencer #(
   parameter logic [3:0]  INIT_OPCODE = 4'h0,
   parameter logic [15:0] NOP_INSTR   = 16'hF000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        prog_we,
   input  logic [3:0]  prog_addr,
   input  logic [15:0] prog_data,
   input  logic        start,
   input  logic [4:0]  prog_len,
   input  logic        init_valid,
   output logic        init_ready,
   input  logic [3:0]  init_reg,
   input  logic [15:0] init_data,
   input  logic        init_last,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic        step,
`endif
   input  logic [15:0] alu_out,
   output logic [15:0] instr_o,
   output logic [15:0] data_init_o,
   output logic        init_sel_o,
   output logic        busy,
   output logic        done,
   output logic [3:0]  pc,
   output logic [15:0] result
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_INIT = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]  state;
   logic [4:0]  len;
   logic [15:0] prog_mem [16];
   logic        adv;
   logic        start_ok;
   logic        last_run;

`ifdef SEQ_SINGLE_STEP_EN
   assign adv = step;
`else
   assign adv = 1'b1;
`endif

   assign start_ok = start && (prog_len != 5'd0) && (prog_len <= 5'd16);
   assign last_run = ({1'b0, pc} == (len - 5'd1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         pc     <= 4'd0;
         result <= 16'h0000;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  state <= S_INIT;
                  len   <= prog_len;
                  pc    <= 4'd0;
               end
            end
            S_INIT: begin
               if (init_valid && init_last) begin
                  state <= S_RUN;
                  pc    <= 4'd0;
               end
            end
            S_RUN: begin
               // pc parks on len-1 so a 16-long program never wraps
               if (adv) begin
                  if (last_run) begin
                     result <= alu_out;
                     state  <= S_DONE;
                  end else begin
                     pc <= pc + 4'd1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Program memory survives reset; writes only land while idle or done
   always_ff @(posedge clk) begin
      if (prog_we && !busy) prog_mem[prog_addr] <= prog_data;
   end

   always_comb begin
      instr_o     = NOP_INSTR;
      data_init_o = 16'h0000;
      init_sel_o  = 1'b0;
      init_ready  = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state)
         S_INIT: begin
            busy       = 1'b1;
            init_ready = 1'b1;
            if (init_valid) begin
               instr_o     = {INIT_OPCODE, init_reg, 8'h00};
               data_init_o = init_data;
            end
         end
         S_RUN: begin
            busy       = 1'b1;
            init_sel_o = 1'b1;
            if (adv) instr_o = prog_mem[pc];
         end
         S_DONE: done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 Parameter INIT_OPCODE, default 4'h0, opcode placed in instr_o[15:12] for init writes; the control decoder asserts write enable for it.
REQ-002 Parameter NOP_INSTR, default 16'hF000, instruction driven whenever no write is intended; opcode 4'hF is non-writing in the control decoder.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 prog_we  in  1  program buffer write strobe.
REQ-006 prog_addr  in  4  program buffer write address.
REQ-007 prog_data  in  16  instruction word to store.
REQ-008 start  in  1  begin sequence (init phase, then run phase).
REQ-009 prog_len  in  5  instruction count, valid range 1..16, sampled on accepted start.
REQ-010 init_valid  in  1  init beat present.
REQ-011 init_ready  out  1  sequencer accepts init beats.
REQ-012 init_reg  in  4  destination register of init beat.
REQ-013 init_data  in  16  value written to init_reg.
REQ-014 init_last  in  1  marks final init beat.
REQ-015 alu_out  in  16  datapath ALU result.
REQ-016 instr_o  out  16  datapath Instruction.
REQ-017 data_init_o  out  16  datapath DataInit.
REQ-018 init_sel_o  out  1  datapath InitSel (0 = DataInit, 1 = ALU result).
REQ-019 busy  out  1  high in INIT and RUN.
REQ-020 done  out  1  one-cycle completion pulse.
REQ-021 pc  out  4  current program index.
REQ-022 result  out  16  alu_out captured on the last RUN cycle.

Function
REQ-023 The FSM SHALL have the states IDLE, INIT, RUN and DONE.
REQ-024 IDLE: start=1 and prog_len in 1..16 -> INIT, latching len; start with prog_len=0 or >16 SHALL be ignored.
REQ-025 INIT: init_ready=1; while init_valid=1, instr_o={INIT_OPCODE,init_reg,8'h00}, data_init_o=init_data, init_sel_o=0 (combinational); else instr_o=NOP_INSTR.
REQ-026 INIT: accepted beat with init_last=1 -> RUN with pc=0; zero-beat init is not supported (at least one beat, e.g. a duplicate write).
REQ-027 RUN: instr_o=prog_mem[pc], init_sel_o=1, data_init_o=0; pc increments every cycle.
REQ-028 RUN with pc==len-1: result<=alu_out at that edge, -> DONE; RUN lasts exactly len cycles.
REQ-029 DONE: done=1, busy=0, instr_o=NOP_INSTR, -> IDLE next cycle; pc holds its final value until the next start.
REQ-030 IDLE/DONE: instr_o=NOP_INSTR, init_sel_o=0, data_init_o=0, init_ready=0.
REQ-031 prog_we SHALL write prog_mem[prog_addr] only when busy=0; writes while busy are dropped.
REQ-032 start while busy=1 or in DONE SHALL be ignored.
REQ-033 pc SHALL not wrap within a run; len=16 ends at pc=15.

Reset
REQ-034 reset SHALL force IDLE, pc=0, result=0, done=0, busy=0, init_ready=0 and instr_o=NOP_INSTR, overriding all other inputs, including mid-INIT and mid-RUN.
REQ-035 prog_mem contents SHALL NOT be cleared by reset.

Configuration
REQ-036 With macro SEQ_SINGLE_STEP_EN defined, an extra input step (1 bit) SHALL be added; in RUN, pc advances and instr_o shows prog_mem[pc] only in cycles with step=1, else NOP_INSTR and pc holds.
REQ-037 Without SEQ_SINGLE_STEP_EN, no step port exists and RUN advances every cycle.

Verification
REQ-038 Load 3 words, start with prog_len=3, two init beats (R1=16'h0005, R2=16'h0003, last on second) -> instr_o shows 16'h0100 then 16'h0200 with init_sel_o=0; RUN 3 cycles; done pulses 1 cycle later.
REQ-039 alu_out stubbed to 16'hBEEF on the final RUN cycle -> result=16'hBEEF after done; busy low.
REQ-040 prog_len=16 -> pc reaches 15, 16 RUN cycles, no wrap; prog_len=0 start -> stays IDLE.
REQ-041 reset asserted in the 2nd RUN cycle -> next cycle IDLE, pc=0, result=0, instr_o=16'hF000; prior program re-runs without reload.
REQ-042 prog_we during RUN to addr 0 with 16'h1234 -> prog_mem[0] unchanged; start during RUN -> ignored.
REQ-043 SEQ_SINGLE_STEP_EN: step pulsed every 3rd cycle, prog_len=2 -> exactly 2 non-NOP RUN instructions, then done.
